fabric_config_frame_loader: RTL and testbench

- Sequences configuration of the fabric's tile switch matrices. Each tile's routing muxes load through column-wide FrameData and per-frame FrameStrobe lines.
- Accepts a 32-bit bitstream word stream over a valid/ready handshake. Hunts for a sync word, then decodes column-write commands.
- Drives registered FrameData plus exactly one one-hot FrameStrobe pulse per configuration frame.
- Sits between the external config port (UART/JTAG word assembler) and the fabric top-level frame distribution.

---
 rtl/fabric_config_frame_loader.sv | 142 ++++++++++++++
 tb/tb_fabric_config_frame_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fabric_config_frame_loader.sv
// Fabric configuration frame loader.
// Hunts a 32-bit word stream for the sync word, decodes column-write commands,
// and emits registered FrameData with a single one-hot FrameStrobe pulse per frame.
module fabric_config_frame_loader #(
  parameter int unsigned FRAME_BITS         = 32,
  parameter int unsigned MAX_FRAMES_PER_COL = 20,
  parameter int unsigned NUM_COLUMNS        = 8,
  parameter logic [31:0] SYNC_WORD          = 32'hFAB0_FAB1
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic [FRAME_BITS-1:0]                     s_data,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  output logic [FRAME_BITS-1:0]                     FrameData,
  output logic [MAX_FRAMES_PER_COL*NUM_COLUMNS-1:0] FrameStrobe,
  output logic                                      cfg_active,
  output logic                                      cfg_error,
  output logic [15:0]                               frames_written
);

  localparam int unsigned STB_W     = MAX_FRAMES_PER_COL * NUM_COLUMNS;
  localparam int unsigned STB_IDX_W = $clog2(STB_W);
  localparam int unsigned COL_W     = $clog2(NUM_COLUMNS);
  localparam int unsigned FCNT_W    = $clog2(MAX_FRAMES_PER_COL + 1);

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_DESYNC = 8'h02;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_CMD,
    ST_DATA,
    ST_ERR_FLUSH
  } state_t;

  state_t              r_state;
  logic [COL_W-1:0]    r_col;
  logic [FCNT_W-1:0]   r_n;
  logic [FCNT_W-1:0]   r_idx;
  logic [FRAME_BITS-1:0] r_frame_data;
  logic [STB_W-1:0]    r_strobe;
  logic                r_active;
  logic                r_error;
  logic [15:0]         r_frames;

  logic [7:0]          w_opcode;
  logic [7:0]          w_cmd_col;
  logic [7:0]          w_cmd_n;
  logic                w_write_bad;
  logic                w_last_frame;
  logic [STB_IDX_W-1:0] w_stb_idx;

  // Command field decode and frame-position arithmetic.
  always_comb begin
    w_opcode     = s_data[31:24];
    w_cmd_col    = s_data[15:8];
    w_cmd_n      = s_data[7:0];
    w_write_bad  = (w_cmd_col >= 8'(NUM_COLUMNS)) || (w_cmd_n == 8'd0) ||
                   (w_cmd_n > 8'(MAX_FRAMES_PER_COL));
    w_last_frame = ((r_idx + FCNT_W'(1)) == r_n);
    w_stb_idx    = STB_IDX_W'(r_col) * STB_IDX_W'(MAX_FRAMES_PER_COL) + STB_IDX_W'(r_idx);
  end

  // Loader FSM with registered frame outputs; strobe defaults low every cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_HUNT;
      r_col        <= '0;
      r_n          <= '0;
      r_idx        <= '0;
      r_frame_data <= '0;
      r_strobe     <= '0;
      r_active     <= 1'b0;
      r_error      <= 1'b0;
      r_frames     <= '0;
    end else begin
      r_strobe <= '0;
      if (s_valid) begin
        case (r_state)
          ST_HUNT, ST_ERR_FLUSH: begin
            if (s_data == SYNC_WORD) begin
              r_state  <= ST_CMD;
              r_active <= 1'b1;
            end
          end
          ST_CMD: begin
            case (w_opcode)
              OP_NOP: begin
              end
              OP_DESYNC: begin
                r_state  <= ST_HUNT;
                r_active <= 1'b0;
              end
              OP_WRITE: begin
                if (w_write_bad) begin
                  r_error  <= 1'b1;
                  r_state  <= ST_ERR_FLUSH;
                  r_active <= 1'b0;
                end else begin
                  r_col   <= w_cmd_col[COL_W-1:0];
                  r_n     <= w_cmd_n[FCNT_W-1:0];
                  r_idx   <= '0;
                  r_state <= ST_DATA;
                end
              end
              default: begin
                r_error  <= 1'b1;
                r_state  <= ST_ERR_FLUSH;
                r_active <= 1'b0;
              end
            endcase
          end
          ST_DATA: begin
            // Sync-word values here are payload, never a resync.
            r_frame_data <= s_data;
            r_strobe     <= STB_W'(1) << w_stb_idx;
            if (r_frames != 16'hFFFF) begin
              r_frames <= r_frames + 16'd1;
            end
            r_idx <= r_idx + FCNT_W'(1);
            if (w_last_frame) begin
              r_state <= ST_CMD;
            end
          end
          default: begin
            r_state <= ST_HUNT;
          end
        endcase
      end
    end
  end

  assign s_ready        = 1'b1;
  assign FrameData      = r_frame_data;
  assign FrameStrobe    = r_strobe;
  assign cfg_active     = r_active;
  assign cfg_error      = r_error;
  assign frames_written = r_frames;

endmodule

// File: tb/tb_fabric_config_frame_loader.sv
// Self-checking bench for fabric_config_frame_loader: vector table plus strobe scoreboard.
module tb_fabric_config_frame_loader;

  localparam int unsigned STB_W = 160;
  localparam logic [31:0] SYNC  = 32'hFAB0_FAB1;

  logic              CLK;
  logic              RST;
  logic [31:0]       s_data;
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       FrameData;
  logic [STB_W-1:0]  FrameStrobe;
  logic              cfg_active;
  logic              cfg_error;
  logic [15:0]       frames_written;

  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic        exp_act;
    logic        exp_err;
    int          stb_bit;   // -1: no strobe expected
  } vec_t;

  typedef struct {
    int          bit_i;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  exp_t mon_e;
  logic [STB_W-1:0] mon_stb;

  int n_tests = 0;
  int n_fail  = 0;

  fabric_config_frame_loader dut (
    .CLK            (CLK),
    .RST            (RST),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .FrameData      (FrameData),
    .FrameStrobe    (FrameStrobe),
    .cfg_active     (cfg_active),
    .cfg_error      (cfg_error),
    .frames_written (frames_written)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] d, input logic v, input logic a,
                              input logic e, input int b);
    vec_t r;
    r.data = d; r.valid = v; r.exp_act = a; r.exp_err = e; r.stb_bit = b;
    return r;
  endfunction

  // Drive one vector for one cycle; queue its expected strobe; check status after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    s_data  = v.data;
    s_valid = v.valid;
    if (v.valid && v.stb_bit >= 0) begin
      e.bit_i = v.stb_bit;
      e.data  = v.data;
      exp_q.push_back(e);
    end
    @(posedge CLK);
    #1;
    chk("s_ready", 32'(s_ready), 32'd1);
    chk("cfg_active", 32'(cfg_active), 32'(v.exp_act));
    chk("cfg_error", 32'(cfg_error), 32'(v.exp_err));
  endtask

  task automatic run_table();
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
    s_valid = 1'b0;
  endtask

  // Strobe monitor: every observed strobe must match the next expected frame.
  always @(negedge CLK) begin
    if (FrameStrobe != '0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got %h expected none", FrameStrobe);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_stb = '0;
        mon_stb[mon_e.bit_i] = 1'b1;
        n_tests++;
        if (FrameStrobe !== mon_stb) begin
          n_fail++;
          $display("FAIL strobe_bit: got %h expected %h", FrameStrobe, mon_stb);
        end
        chk("frame_data", FrameData, mon_e.data);
      end
    end
  end

  initial begin
    RST     = 1'b1;
    s_data  = '0;
    s_valid = 1'b0;
    #12;
    chk("rst_active", 32'(cfg_active), 32'd0);
    chk("rst_error", 32'(cfg_error), 32'd0);
    chk("rst_frames", 32'(frames_written), 32'd0);
    chk("rst_fdata", FrameData, 32'd0);
    chk("rst_strobe", 32'(FrameStrobe != '0), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Hunt, then col 2 / 3 frames back-to-back.
    vecs.push_back(mk(32'h1234_5678, 1, 0, 0, -1));
    vecs.push_back(mk(SYNC,          0, 0, 0, -1));
    vecs.push_back(mk(SYNC,          1, 1, 0, -1));
    vecs.push_back(mk(32'h0100_0203, 1, 1, 0, -1));
    vecs.push_back(mk(32'hAAAA_0001, 1, 1, 0, 40));
    vecs.push_back(mk(32'hBBBB_0002, 1, 1, 0, 41));
    vecs.push_back(mk(32'hCCCC_0003, 1, 1, 0, 42));
    vecs.push_back(mk(32'h0000_0000, 1, 1, 0, -1));
    run_table();
    chk("frames_after_3", 32'(frames_written), 32'd3);
    chk("fdata_hold", FrameData, 32'hCCCC_0003);

    // Col 7, 20 frames, valid toggling every other cycle.
    vecs.push_back(mk(32'h0100_0714, 1, 1, 0, -1));
    for (int i = 0; i < 20; i++) begin
      vecs.push_back(mk(32'h7000_0000 + 32'(i), 1, 1, 0, 140 + i));
      vecs.push_back(mk(32'hFFFF_FFFF, 0, 1, 0, -1));
    end
    // Error cases with flush and recovery.
    vecs.push_back(mk(32'h0100_0801, 1, 0, 1, -1));
    vecs.push_back(mk(32'h0100_0001, 1, 0, 1, -1));
    vecs.push_back(mk(32'hDEAD_BEEF, 1, 0, 1, -1));
    vecs.push_back(mk(SYNC,          1, 1, 1, -1));
    vecs.push_back(mk(32'h0100_0100, 1, 0, 1, -1));
    vecs.push_back(mk(SYNC,          1, 1, 1, -1));
    vecs.push_back(mk(32'h5500_0000, 1, 0, 1, -1));
    vecs.push_back(mk(SYNC,          1, 1, 1, -1));
    vecs.push_back(mk(32'h0100_0015, 1, 0, 1, -1));
    vecs.push_back(mk(SYNC,          1, 1, 1, -1));
    vecs.push_back(mk(32'h0100_0101, 1, 1, 1, -1));
    vecs.push_back(mk(32'h1111_1111, 1, 1, 1, 20));
    // Sync word inside DATA is payload.
    vecs.push_back(mk(32'h0100_0301, 1, 1, 1, -1));
    vecs.push_back(mk(SYNC,          1, 1, 1, 60));
    vecs.push_back(mk(32'h0000_0000, 1, 1, 1, -1));
    run_table();
    chk("frames_after_25", 32'(frames_written), 32'd25);
    chk("queue_drained_a", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a 2-frame write.
    apply(mk(32'h0100_0002, 1, 1, 1, -1));
    apply(mk(32'hAAAA_0001, 1, 1, 1, 0));
    s_valid = 1'b0;
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("async_rst_active", 32'(cfg_active), 32'd0);
    chk("async_rst_error", 32'(cfg_error), 32'd0);
    chk("async_rst_frames", 32'(frames_written), 32'd0);
    chk("async_rst_fdata", FrameData, 32'd0);
    chk("async_rst_strobe", 32'(FrameStrobe != '0), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    apply(mk(32'h5555_5555, 1, 0, 0, -1));
    apply(mk(32'h6666_6666, 1, 0, 0, -1));
    s_valid = 1'b0;
    chk("post_rst_frames", 32'(frames_written), 32'd0);

    // Desync, then WRITE-format words are ignored.
    vecs.push_back(mk(SYNC,          1, 1, 0, -1));
    vecs.push_back(mk(32'h0000_0000, 1, 1, 0, -1));
    vecs.push_back(mk(32'h0200_0000, 1, 0, 0, -1));
    vecs.push_back(mk(32'h0100_0001, 1, 0, 0, -1));
    vecs.push_back(mk(32'h1234_0000, 1, 0, 0, -1));
    run_table();
    repeat (2) @(posedge CLK);
    #1;
    chk("final_frames", 32'(frames_written), 32'd0);
    chk("queue_drained_end", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
